// File: rtl/imem_pkg.sv
// Shared types and constants for the synchronous instruction memory.
// The boot image is consumed only when IMEM_BOOT_EN is defined.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        BOOT = 2'd3
    } state_e;

    localparam int BOOT_LEN = 6;

    localparam logic [15:0] BOOT_IMAGE [BOOT_LEN] = '{
        16'h8180, 16'h2CB2, 16'hDC67, 16'hDDD9, 16'hFDB1, 16'hC07B
    };

    function automatic int clog2(input int value);
        int res;
        res = 32'sd0;
        for (int i = 32'sd0; i < 32'sd31; i++) begin
            if ((32'sd1 << res) < value) begin
                res = res + 32'sd1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/imem_sync_if.sv
// Fetch and program-load bus of imem_sync; master = fetch stage/loader, slave = memory.
interface imem_sync_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 16
);
    logic              fetch_req;
    logic [PC_W-1:0]   fetch_pc;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_fault;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;
    logic              busy;

    modport master (
        output fetch_req, fetch_pc, load_start, load_valid, load_data,
        input  fetch_ready, fetch_valid, fetch_instr, fetch_fault,
               load_ready, load_done, busy
    );

    modport slave (
        input  fetch_req, fetch_pc, load_start, load_valid, load_data,
        output fetch_ready, fetch_valid, fetch_instr, fetch_fault,
               load_ready, load_done, busy
    );
endinterface

// File: rtl/imem_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port, no reset.
// With IMEM_BOOT_EN the array starts out holding the package boot image.
module imem_ram
    import imem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    typedef logic [DATA_W-1:0] mem_t [DEPTH];

`ifdef IMEM_BOOT_EN
    function automatic mem_t boot_init();
        mem_t img;
        for (int i = 32'sd0; i < DEPTH; i++) begin
            if (i < BOOT_LEN) begin
                img[i] = DATA_W'(BOOT_IMAGE[i]);
            end else begin
                img[i] = {DATA_W{1'b0}};
            end
        end
        return img;
    endfunction

    mem_t mem_q = boot_init();
`else
    mem_t mem_q;
`endif

    logic [DATA_W-1:0] rd_data_q;

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read port: the output holds between enabled reads
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/imem_sync.sv
// Synchronous instruction memory with a registered fetch port, a runtime load FSM and fault reporting.
// Define IMEM_BOOT_EN to preload the boot image and come out of reset ready to fetch.
module imem_sync
    import imem_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int PC_W     = 16,
    parameter int DEPTH    = 16,
    parameter int PC_SHIFT = 2
) (
    input  logic       clk,
    input  logic       reset,
    imem_sync_if.slave bus
);
    localparam int AW = clog2(DEPTH);
    localparam int LW = PC_W + 1;
    // One extra bit so a memory covering the whole PC space does not wrap to 0
    localparam logic [LW-1:0] PC_LIMIT = LW'(DEPTH) << PC_SHIFT;

`ifdef IMEM_BOOT_EN
    localparam state_e RESET_STATE = BOOT;
    if (DATA_W != 16 || DEPTH < BOOT_LEN) begin : g_bad_boot
        $error("imem_sync: boot image needs DATA_W=16 and DEPTH>=6");
    end
`else
    localparam state_e RESET_STATE = IDLE;
`endif

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("imem_sync: DEPTH must be a power of two, at least 2");
    end

    state_e            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic              zero_q, zero_d;
    logic              fetch_ready_s, load_ready_s, busy_s, wr_en_s;
    logic              accept_s, range_fault_s, misalign_s, fault_s;
    logic [DATA_W-1:0] rd_data_s;

    if (PC_SHIFT > 0) begin : g_align
        assign misalign_s = |bus.fetch_pc[PC_SHIFT-1:0];
    end else begin : g_no_align
        assign misalign_s = 1'b0;
    end

    assign range_fault_s = {1'b0, bus.fetch_pc} >= PC_LIMIT;
    assign fault_s       = range_fault_s | misalign_s;
    assign accept_s      = bus.fetch_req & fetch_ready_s;

    imem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (ptr_q),
        .wr_data (bus.load_data),
        .rd_en   (accept_s & ~fault_s),
        .rd_addr (bus.fetch_pc[PC_SHIFT +: AW]),
        .rd_data (rd_data_s)
    );

    // Load FSM: next state, write pointer and handshake decode
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        done_d        = 1'b0;
        wr_en_s       = 1'b0;
        fetch_ready_s = 1'b0;
        load_ready_s  = 1'b0;
        busy_s        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d = LOAD;
                    ptr_d   = {AW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                busy_s       = 1'b1;
                load_ready_s = 1'b1;
                if (bus.load_start) begin
                    ptr_d = {AW{1'b0}};
                end else if (bus.load_valid) begin
                    wr_en_s = 1'b1;
                    if (ptr_q == AW'(DEPTH - 1)) begin
                        ptr_d   = {AW{1'b0}};
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end else begin
                    ptr_d = ptr_q;
                end
            end
            RUN, BOOT: begin
                fetch_ready_s = 1'b1;
                if (bus.load_start) begin
                    state_d = LOAD;
                    ptr_d   = {AW{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = {AW{1'b0}};
            end
        endcase
    end

    // Fetch response: zero_q forces a NOP after reset or a faulting fetch
    always_comb begin
        valid_d = accept_s;
        fault_d = accept_s & fault_s;
        if (accept_s) begin
            zero_d = fault_s;
        end else begin
            zero_d = zero_q;
        end
    end

    // State and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_STATE;
            ptr_q   <= {AW{1'b0}};
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.fetch_ready = fetch_ready_s;
    assign bus.load_ready  = load_ready_s;
    assign bus.busy        = busy_s;
    assign bus.load_done   = done_q;
    assign bus.fetch_valid = valid_q;
    assign bus.fetch_fault = fault_q;
    assign bus.fetch_instr = zero_q ? {DATA_W{1'b0}} : rd_data_s;
endmodule

// File: doc/imem_sync.md
Name: imem_sync

Overview:
- Parametrised synchronous instruction memory; next generation of the combinational 16-word instruction ROM.
- Adds a registered fetch port with a req/ready/valid handshake and a runtime program-load port driven by a small FSM.
- Reports out-of-range and misaligned fetches as faults.
- Sits between the PC/fetch stage and an external loader (UART/JTAG bridge or testbench).

Parameters:
- DATA_W, 16, instruction width in bits.
- PC_W, 16, fetch PC width in bits.
- DEPTH, 16, words of storage; must be a power of two, minimum 2.
- PC_SHIFT, 2, PC byte-offset bits dropped to form the word address (word = pc >> PC_SHIFT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  fetch request.
- fetch_pc  in  PC_W  fetch byte address.
- fetch_ready  out  1  fetch accepted this cycle when high together with fetch_req.
- fetch_valid  out  1  one-cycle pulse; response data valid.
- fetch_instr  out  DATA_W  fetched instruction.
- fetch_fault  out  1  qualifies fetch_valid; address out of range or misaligned.
- load_start  in  1  begin or restart program load at word 0.
- load_valid  in  1  load_data valid.
- load_data  in  DATA_W  word to write.
- load_ready  out  1  write accepted when high together with load_valid.
- load_done  out  1  one-cycle pulse after the last word is written.
- busy  out  1  high while the FSM is in LOAD.

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - FSM to IDLE (BOOT when IMEM_BOOT_EN).
  - load pointer to 0.
  - fetch_valid, fetch_fault and load_done to 0.
  - fetch_instr to 0.
- Storage array is not reset. Reset mid-load aborts the load; words already written are retained.
- FSM states:
  - IDLE: fetch_ready=0, load_ready=0. load_start -> LOAD.
  - LOAD: busy=1, load_ready=1, fetch_ready=0.
    - Each load_valid&&load_ready writes mem[ptr] and increments ptr.
    - The write at ptr==DEPTH-1 goes to RUN, resets ptr to 0 and pulses load_done the following cycle.
    - load_start in LOAD takes priority over load_valid in the same cycle: ptr=0, no write.
  - RUN (and BOOT): fetch_ready=1, load_ready=0. load_start -> LOAD; a fetch accepted in that same cycle still completes.
- Fetch timing:
  - Accept = fetch_req && fetch_ready.
  - Result is registered: fetch_valid=1 exactly one cycle after accept.
  - Back-to-back fetches give one response per cycle.
- Fault: fetch_pc >= DEPTH<<PC_SHIFT, or fetch_pc[PC_SHIFT-1:0] != 0 (skipped when PC_SHIFT=0).
  - On fault: fetch_fault=1, fetch_instr=0 (NOP).
  - Otherwise: fetch_fault=0, fetch_instr=mem[fetch_pc[PC_SHIFT +: log2(DEPTH)]].
- Without an accept, fetch_valid=0 and fetch_fault=0; fetch_instr holds its last value.
- fetch_req while not ready is ignored (not queued); the requester retries.
- load_valid outside LOAD is ignored.
- Width rule: compare fetch_pc in PC_W+1 bits so DEPTH<<PC_SHIFT == 2^PC_W does not overflow; in that case every aligned PC is in range.

Optional Feature:
- Macro: IMEM_BOOT_EN.
- Defined:
  - Storage is initialised at elaboration with the boot image from the package; remaining words are 0.
  - Reset state is BOOT, which behaves as RUN, so fetches work immediately after reset.
  - Runtime load still allowed.
- Undefined:
  - Reset state is IDLE; fetches are refused until a load completes.
  - Storage initial contents are don't-care.
- Boot image:
  - word0 16'h8180, word1 16'h2CB2, word2 16'hDC67, word3 16'hDDD9, word4 16'hFDB1, word5 16'hC07B.
  - Requires DATA_W=16 and DEPTH>=6; elaboration error otherwise.

Decomposition:
- Package imem_pkg: FSM state enum (IDLE, LOAD, RUN, BOOT), boot image constant array, boot length constant 6, clog2 helper.
- One natural sub-module imem_ram: DEPTH x DATA_W array with one synchronous write port and one synchronous registered read port, no reset.
- Address decode, fault logic and FSM stay in imem_sync.

Test Plan:
- Reset then load_start, followed by 16 consecutive load_valid words 16'h1000+i: load_ready high for all 16; load_done pulses once, one cycle after word 15; busy falls and FSM enters RUN. Then fetch_pc=0x0008 -> fetch_valid one cycle later, fetch_instr=16'h1002, fetch_fault=0.
- Back-to-back fetch_pc 0x0000, 0x0004, 0x003C -> three consecutive fetch_valid pulses: 16'h1000, 16'h1001, 16'h100F.
- fetch_pc=0x0040 -> fetch_fault=1, instr=0. fetch_pc=0x0006 -> fetch_fault=1, instr=0.
- Assert reset after 5 words loaded -> FSM returns to IDLE, fetch_ready=0. A new load of 16 words completes normally; words 0-4 are overwritten.
- load_start asserted in the same cycle as load_valid during LOAD -> no write, ptr restarts at 0; 16 further words are required before load_done.
- IMEM_BOOT_EN defined: reset, then fetch 0x0000 and 0x0014 -> 16'h8180 and 16'h C07B (i.e. 16'hC07B) with no load; fetch 0x0018 -> 16'h0000, no fault.
